// File: rtl/pll_reset_seq.sv
// PLL lock qualifier: synchronizes PLL LOCK and generates a glitch-free system reset in the PLL clock domain.
// Optional lock-loss event counter enabled by defining PLL_RESET_LOSS_CNT_EN.
module pll_reset_seq #(
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             sys_rst_n,
    output logic             sys_rst,
    output logic [1:0]       state,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lost_count
);

    localparam int MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync1_q, locked_s_q;
    logic            sys_rst_n_q, sys_rst_q;
    logic            lock_lost_q, loss_d;

    // Two-stage synchronizer; the only logic that samples pll_locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= (state_d == ST_RUN);
            sys_rst_q   <= (state_d != ST_RUN);
            lock_lost_q <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // any low cycle of the synchronized lock restarts qualification
                if (!locked_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    loss_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PLL_RESET_LOSS_CNT_EN
    logic [CNT_W-1:0] lost_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt_q <= '0;
        end else if (loss_d && (lost_cnt_q != {CNT_W{1'b1}})) begin
            lost_cnt_q <= lost_cnt_q + 1'b1;
        end
    end

    assign lost_count = lost_cnt_q;
`else
    assign lost_count = '0;
`endif

    assign sys_rst_n = sys_rst_n_q;
    assign sys_rst   = sys_rst_q;
    assign state     = state_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_CYCLES=8, HOLD_CYCLES=4, CNT_W=2.
module tb_pll_reset_seq;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sys_rst_n;
    logic       sys_rst;
    logic [1:0] state;
    logic       lock_lost;
    logic [1:0] lost_count;

    int checks = 0;
    int errors = 0;

`ifdef PLL_RESET_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    pll_reset_seq #(
        .LOCK_CYCLES(8),
        .HOLD_CYCLES(4),
        .CNT_W      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .sys_rst_n (sys_rst_n),
        .sys_rst   (sys_rst),
        .state     (state),
        .lock_lost (lock_lost),
        .lost_count(lost_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks n edges; reset must stay asserted for n-1 edges and release on the n-th.
    task automatic expect_release(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk({tag, "_rst_n"}, {7'd0, sys_rst_n}, (i == n) ? 8'd1 : 8'd0);
            chk({tag, "_lost"}, {7'd0, lock_lost}, 8'd0);
        end
        chk({tag, "_state"}, {6'd0, state}, 8'd2);
        chk({tag, "_rst"}, {7'd0, sys_rst}, 8'd0);
    endtask

    function automatic logic [7:0] exp_lost(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 3) ? 8'd3 : 8'(n);
    endfunction

    initial begin
        // reset state
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
        chk("rst_sys_rst", {7'd0, sys_rst}, 8'd1);
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_lock_lost", {7'd0, lock_lost}, 8'd0);
        chk("rst_lost_count", {6'd0, lost_count}, 8'd0);

        // stable lock from power-on: HOLD edges 1-4, WAIT edges 5-12, RUN after edge 12
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("pwr_state", {6'd0, state}, (k <= 3) ? 8'd0 : ((k <= 11) ? 8'd1 : 8'd2));
            chk("pwr_rst_n", {7'd0, sys_rst_n}, (k == 12) ? 8'd1 : 8'd0);
        end
        chk("pwr_rst", {7'd0, sys_rst}, 8'd0);

        // lock loss in RUN: reset drops on the third edge, lock_lost pulses once
        pll_locked = 1'b0;
        tick();
        chk("loss_e1_state", {6'd0, state}, 8'd2);
        chk("loss_e1_rst_n", {7'd0, sys_rst_n}, 8'd1);
        tick();
        chk("loss_e2_state", {6'd0, state}, 8'd2);
        chk("loss_e2_rst_n", {7'd0, sys_rst_n}, 8'd1);
        chk("loss_e2_lost", {7'd0, lock_lost}, 8'd0);
        tick();
        chk("loss_e3_state", {6'd0, state}, 8'd0);
        chk("loss_e3_rst_n", {7'd0, sys_rst_n}, 8'd0);
        chk("loss_e3_rst", {7'd0, sys_rst}, 8'd1);
        chk("loss_e3_lost", {7'd0, lock_lost}, 8'd1);
        chk("loss_e3_count", {6'd0, lost_count}, exp_lost(1));
        pll_locked = 1'b1;
        expect_release(12, "relock");

        // asynchronous reset in RUN, checked before any further clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_n", {7'd0, sys_rst_n}, 8'd0);
        chk("async_rst", {7'd0, sys_rst}, 8'd1);
        chk("async_state", {6'd0, state}, 8'd0);
        chk("async_lost", {7'd0, lock_lost}, 8'd0);
        chk("async_count", {6'd0, lost_count}, 8'd0);

        // lock absent until edge 20: release on the 10th edge counting edge 20
        pll_locked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) tick();
        chk("late_state", {6'd0, state}, 8'd1);
        chk("late_rst_n", {7'd0, sys_rst_n}, 8'd0);
        pll_locked = 1'b1;
        expect_release(10, "late");

        // one-cycle lock drop in WAIT at cnt=5 restarts qualification
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) tick();
        chk("glitch_state", {6'd0, state}, 8'd1);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        expect_release(10, "glitch");

        // repeated lock losses exercise the saturating counter
        for (int j = 1; j <= 5; j++) begin
            pll_locked = 1'b0;
            tick();
            tick();
            chk("multi_pre_state", {6'd0, state}, 8'd2);
            tick();
            chk("multi_state", {6'd0, state}, 8'd0);
            chk("multi_lost", {7'd0, lock_lost}, 8'd1);
            chk("multi_count", {6'd0, lost_count}, exp_lost(j));
            pll_locked = 1'b1;
            expect_release(12, "multi");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
